// File: rtl/player_piano_pkg.sv
// Shared player-piano definitions: mode encodings, song word layout and song_reader FSM states.
package player_piano_pkg;

  typedef enum logic [1:0] {
    JAM_SESH    = 2'b00,
    COMPOSER    = 2'b01,
    SONG_PLAYER = 2'b10
  } mode_e;

  localparam int unsigned NOTE_W   = 6;
  localparam int unsigned NOTE_LSB = 0;
  localparam int unsigned DUR_W    = 6;
  localparam int unsigned DUR_LSB  = 6;
  localparam int unsigned WORD_W   = 12;

  localparam logic [WORD_W-1:0] END_MARKER = 12'h000;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_WAIT_ROM   = 3'd2,
    S_ISSUE      = 3'd3,
    S_WAIT_BEATS = 3'd4,
    S_DONE       = 3'd5
  } fsm_e;

  typedef struct packed {
    logic [DUR_W-1:0]  duration;
    logic [NOTE_W-1:0] note;
  } song_word_t;

  function automatic logic [WORD_W-1:0] mk_word(input logic [DUR_W-1:0]  dur,
                                                input logic [NOTE_W-1:0] note);
    return (WORD_W'(dur) << DUR_LSB) | (WORD_W'(note) << NOTE_LSB);
  endfunction

  function automatic logic [DUR_W-1:0] dur_of(input logic [WORD_W-1:0] w);
    return w[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Note stream from song_reader to the note-to-sample stage.
interface song_reader_if #(
  parameter int unsigned IDX_W = 2
);
  import player_piano_pkg::*;

  logic [WORD_W-1:0] song_note;
  logic              load_new_note;
  logic              song_done;
  logic [IDX_W-1:0]  song_idx;

  modport master (output song_note, output load_new_note, output song_done, output song_idx);
  modport slave  (input  song_note, input  load_new_note, input  song_done, input  song_idx);

endinterface

// File: rtl/song_rom.sv
// Synchronous-read song ROM, one-cycle latency, addressed {song, position}.
module song_rom
  import player_piano_pkg::*;
#(
  parameter int unsigned SONG_ADDR_W = 7,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                         clk,
  input  logic [IDX_W+SONG_ADDR_W-1:0] addr,
  output logic [WORD_W-1:0]            data
);

  logic [IDX_W-1:0]       song;
  logic [SONG_ADDR_W-1:0] pos;
  logic [WORD_W-1:0]      word_c;

  assign song = addr[SONG_ADDR_W +: IDX_W];
  assign pos  = addr[SONG_ADDR_W-1:0];

  // Song 3 has no end marker: it runs off the top of its address space.
  always_comb begin
    word_c = END_MARKER;
    case (song)
      IDX_W'(0): if (pos == '0) word_c = mk_word(6'd2, 6'd4);
      IDX_W'(1): begin
        case (pos)
          SONG_ADDR_W'(0): word_c = mk_word(6'd0, 6'd4);
          SONG_ADDR_W'(1): word_c = mk_word(6'd0, 6'd6);
          SONG_ADDR_W'(2): word_c = mk_word(6'd1, 6'd8);
          default:         word_c = END_MARKER;
        endcase
      end
      IDX_W'(2): if (pos == '0) word_c = mk_word(6'd4, 6'd10);
      default:   word_c = (pos == '0) ? mk_word(6'd1, 6'd63)
                                      : mk_word(6'd0, {1'b1, pos[4:0]});
    endcase
  end

  always_ff @(posedge clk) data <= word_c;

endmodule

// File: rtl/song_reader.sv
// Song-player sequencer: walks the current song in song_rom and strobes notes timed by beats.
// Build option SONG_LOOP_EN: after song_done the song restarts from its first word.
module song_reader
  import player_piano_pkg::*;
#(
  parameter int unsigned SONG_ADDR_W = 7,
  parameter int unsigned NUM_SONGS   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    state,
  input  logic          play,
  input  logic          next_song,
  input  logic          beat,
  song_reader_if.master notes
);

  localparam int unsigned IDX_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  fsm_e                 cur, nxt;
  logic [SONG_ADDR_W:0] addr, addr_n;
  logic [IDX_W-1:0]     idx, idx_n, idx_inc;
  logic [DUR_W-1:0]     cnt, cnt_n, dur;
  logic                 hold, hold_n;
  logic [WORD_W-1:0]    note_q, note_n, rom_data, rom_word;
  logic                 load_q, load_n, done_q, done_n;
  logic                 active, is_end;

  assign active   = (state == SONG_PLAYER) && play;
  // The extra address bit marks a step past the last word; it reads as the end marker.
  assign rom_word = addr[SONG_ADDR_W] ? END_MARKER : rom_data;
  assign is_end   = (note_q == END_MARKER);
  assign dur      = dur_of(note_q);
  assign idx_inc  = (idx == IDX_W'(NUM_SONGS - 1)) ? '0 : idx + IDX_W'(1);

  song_rom #(
    .SONG_ADDR_W(SONG_ADDR_W),
    .IDX_W      (IDX_W)
  ) u_rom (
    .clk (clk),
    .addr({idx, addr[SONG_ADDR_W-1:0]}),
    .data(rom_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (next_song) begin
      nxt = S_IDLE;
    end else if (active) begin
      unique case (cur)
        S_IDLE:       if (!hold) nxt = S_FETCH;
        S_FETCH:      nxt = S_WAIT_ROM;
        S_WAIT_ROM:   nxt = S_ISSUE;
        S_ISSUE:      nxt = is_end ? S_DONE : ((dur == '0) ? S_FETCH : S_WAIT_BEATS);
        S_WAIT_BEATS: if (beat && cnt == DUR_W'(1)) nxt = S_FETCH;
        S_DONE:       nxt = LOOP ? S_FETCH : S_IDLE;
        default:      nxt = S_IDLE;
      endcase
    end
  end

  // Datapath next values and the registered strobes; hold blocks a restart until play is re-pressed.
  always_comb begin
    addr_n = addr;
    idx_n  = idx;
    cnt_n  = cnt;
    hold_n = hold & play;
    note_n = note_q;
    load_n = 1'b0;
    done_n = 1'b0;
    if (next_song) begin
      idx_n  = idx_inc;
      addr_n = '0;
      cnt_n  = '0;
      hold_n = 1'b0;
    end else if (active) begin
      unique case (cur)
        S_WAIT_ROM: begin
          note_n = rom_word;
          load_n = (rom_word != END_MARKER);
        end
        S_ISSUE: begin
          if (is_end)         done_n = 1'b1;
          else if (dur == '0) addr_n = addr + (SONG_ADDR_W+1)'(1);
          else                cnt_n  = dur;
        end
        S_WAIT_BEATS: begin
          if (beat) begin
            cnt_n = cnt - DUR_W'(1);
            if (cnt == DUR_W'(1)) addr_n = addr + (SONG_ADDR_W+1)'(1);
          end
        end
        S_DONE: begin
          addr_n = '0;
          hold_n = !LOOP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr   <= '0;
      idx    <= '0;
      cnt    <= '0;
      hold   <= 1'b0;
      note_q <= END_MARKER;
      load_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr   <= addr_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      hold   <= hold_n;
      note_q <= note_n;
      load_q <= load_n;
      done_q <= done_n;
    end
  end

  assign notes.song_note     = note_q;
  assign notes.load_new_note = load_q;
  assign notes.song_done     = done_q;
  assign notes.song_idx      = idx;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: stimulus queues expected strobes/done pulses, a monitor checks them.
module tb_song_reader;
  import player_piano_pkg::*;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic [1:0] state     = 2'b00;
  logic       play      = 1'b0;
  logic       next_song = 1'b0;
  logic       beat      = 1'b0;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_done;
    logic [11:0] val;
    int          at;
  } exp_t;
  exp_t sb[$];

  song_reader_if notes ();

  song_reader #(.SONG_ADDR_W(7), .NUM_SONGS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .state    (state),
    .play     (play),
    .next_song(next_song),
    .beat     (beat),
    .notes    (notes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_note(input logic [11:0] v, input int at);
    exp_t e;
    e.is_done = 1'b0; e.val = v; e.at = at;
    sb.push_back(e);
  endtask

  task automatic expect_done(input int at);
    exp_t e;
    e.is_done = 1'b1; e.val = 12'h000; e.at = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    beat      = 1'b0;
    next_song = 1'b0;
  endtask

  task automatic run_until(input int t);
    if (cyc > t) begin
      total++; bad++;
      $display("FAIL schedule cyc=%0d want=%0d", cyc, t);
    end
    while (cyc < t) tick();
  endtask

  task automatic beat_at(input int t);
    run_until(t);
    beat = 1'b1;
  endtask

  task automatic song_at(input int t);
    run_until(t);
    next_song = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (notes.load_new_note === 1'b1 || notes.song_done === 1'b1)) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event cyc=%0d got strobe=%0b done=%0b note=%h want none",
                   cyc, notes.load_new_note, notes.song_done, notes.song_note);
        end else begin
          e = sb.pop_front();
          check("event_kind", 32'(notes.song_done), 32'(e.is_done));
          if (!e.is_done) check("note_value", 32'(notes.song_note), 32'(e.val));
          check("event_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1);
  end

  initial begin
    int   c;
    exp_t e;
    fork monitor(); join_none

    #2 reset = 1'b0;
    repeat (3) tick();
    check("rst_note", 32'(notes.song_note), 32'h000);
    check("rst_load", 32'(notes.load_new_note), 32'h0);
    check("rst_done", 32'(notes.song_done), 32'h0);
    check("rst_idx",  32'(notes.song_idx), 32'h0);
    reset = 1'b1;
    tick();

    // Song 0: two-beat note, beat in the issue cycle is ignored
    c = cyc; state = SONG_PLAYER; play = 1'b1;
    expect_note(12'h084, c + 3);
    expect_done(c + 17);
`ifdef SONG_LOOP_EN
    expect_note(12'h084, c + 20);
`endif
    beat_at(c + 3); beat_at(c + 8); beat_at(c + 13);
    run_until(c + 21); play = 1'b0;
    song_at(c + 22);
    run_until(c + 24);
    check("idx_song1", 32'(notes.song_idx), 32'h1);

    // Song 1: chord members every 3 cycles, then a one-beat note
    c = cyc; play = 1'b1;
    expect_note(12'h004, c + 3);
    expect_note(12'h006, c + 6);
    expect_note(12'h048, c + 9);
    expect_done(c + 16);
    beat_at(c + 12);
    run_until(c + 17); play = 1'b0;
    song_at(c + 18);
    run_until(c + 20);
    check("idx_song2", 32'(notes.song_idx), 32'h2);

    // Song 2: four-beat note with a pause spanning three beats
    c = cyc; play = 1'b1;
    expect_note(12'h10A, c + 3);
    expect_done(c + 39);
    beat_at(c + 5); beat_at(c + 10);
    run_until(c + 11); play = 1'b0;
    beat_at(c + 15); beat_at(c + 20); beat_at(c + 25);
    run_until(c + 27); play = 1'b1;
    beat_at(c + 30); beat_at(c + 35);
    run_until(c + 40); play = 1'b0;
    song_at(c + 41);
    run_until(c + 43);
    check("idx_song3", 32'(notes.song_idx), 32'h3);

    // Song 3: next_song collides with the terminating beat, wraps to song 0
    c = cyc; play = 1'b1;
    expect_note(12'h07F, c + 3);
    beat_at(c + 5); next_song = 1'b1;
    run_until(c + 6);
    check("idx_wrap", 32'(notes.song_idx), 32'h0);
    expect_note(12'h084, c + 9);
    run_until(c + 10); play = 1'b0;
    song_at(c + 11); song_at(c + 12); song_at(c + 13);
    run_until(c + 15);
    check("idx_back3", 32'(notes.song_idx), 32'h3);

    // Song 3 again: 127 chord words then end of address space
    c = cyc; play = 1'b1;
    expect_note(12'h07F, c + 3);
    for (int k = 1; k < 128; k++) expect_note(12'h020 | 12'(k & 31), c + 6 + 3 * k);
    expect_done(c + 391);
    beat_at(c + 6);
    run_until(c + 392); play = 1'b0;
    song_at(c + 393); song_at(c + 394); song_at(c + 395);
    run_until(c + 397);
    check("idx_song2b", 32'(notes.song_idx), 32'h2);

    // Song 2 interrupted by reset while waiting for beats
    c = cyc; play = 1'b1;
    expect_note(12'h10A, c + 3);
    run_until(c + 6);
    reset = 1'b0;
    #1;
    check("mid_rst_note", 32'(notes.song_note), 32'h000);
    check("mid_rst_idx",  32'(notes.song_idx), 32'h0);
    check("mid_rst_load", 32'(notes.load_new_note), 32'h0);
    check("mid_rst_done", 32'(notes.song_done), 32'h0);
    tick();
    reset = 1'b1;
    expect_note(12'h084, c + 10);
    expect_done(c + 18);
    beat_at(c + 12); beat_at(c + 14);
    run_until(c + 19); play = 1'b0;

    // Jam mode: sequencer must stay idle
    run_until(c + 20); state = JAM_SESH; play = 1'b1; next_song = 1'b1;
    tick();
    check("idx_jam", 32'(notes.song_idx), 32'h1);
    for (int i = 0; i < 20; i++) begin
      check("jam_no_strobe", 32'(notes.load_new_note), 32'h0);
      tick();
    end
    c = cyc; state = SONG_PLAYER;
    expect_note(12'h004, c + 3);
    expect_note(12'h006, c + 6);
    expect_note(12'h048, c + 9);
    expect_done(c + 16);
    beat_at(c + 12);
    run_until(c + 17); play = 1'b0;
    run_until(c + 24);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL missing_event got none want done=%0b note=%h at=%0d", e.is_done, e.val, e.at);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 SHALL have parameter SONG_ADDR_W, default 7, meaning note-address width per song (128 note words per song).
REQ-002 SHALL have parameter NUM_SONGS, default 4, meaning number of songs in the song ROM; song index width is 2.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port state  input  2  player mode; 2'b00 jam session, 2'b01 composer, 2'b10 song player.
REQ-006 SHALL have port play  input  1  level; 1 = run, 0 = pause.
REQ-007 SHALL have port next_song  input  1  single-cycle pulse; advance to the next song.
REQ-008 SHALL have port beat  input  1  single-cycle beat-tick pulse.
REQ-009 SHALL have port song_note  output  12  {duration[11:6], note[5:0]} presented to the note-to-sample stage.
REQ-010 SHALL have port load_new_note  output  1  single-cycle strobe; song_note valid in that cycle.
REQ-011 SHALL have port song_done  output  1  single-cycle pulse at end of song.
REQ-012 SHALL have port song_idx  output  2  index of the current song.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_BEATS and DONE.
REQ-014 SHALL be active only when state==2'b10 and play==1; otherwise it holds its FSM state, counters and address, and keeps load_new_note at 0.
REQ-015 SHALL transition IDLE->FETCH on the first active cycle.
REQ-016 SHALL, in FETCH, drive ROM address {song_idx, addr}, then move to WAIT_ROM; ROM read latency is exactly 1 cycle.
REQ-017 SHALL, in WAIT_ROM, register the ROM word and then enter ISSUE.
REQ-018 SHALL treat word 12'h000 as the end marker: enter DONE with no strobe issued.
REQ-019 SHALL, for any word other than 12'h000, assert load_new_note for exactly one cycle in ISSUE with song_note equal to the word.
REQ-020 SHALL, for a word with duration==0 and note!=0 (chord member), go ISSUE->FETCH with addr+1 and no beat wait, producing one strobe every 3 cycles.
REQ-021 SHALL, for a word with duration>=1, load the beat counter with duration, enter WAIT_BEATS and decrement on each beat pulse.
REQ-022 SHALL, on the beat that takes the beat counter to 0, go to FETCH with addr+1; a beat in the ISSUE cycle is not counted.
REQ-023 SHALL, in DONE, pulse song_done for one cycle, reset addr to 0 and go to IDLE.
REQ-024 SHALL treat an addr increment past 2^SONG_ADDR_W-1 as end of song; it behaves exactly as the end marker, with no wrap into the next song.
REQ-025 SHALL, on next_song, set song_idx to (song_idx+1) mod NUM_SONGS, set addr and the beat counter to 0, and go to IDLE from any state.
REQ-026 SHALL give next_song priority over beat, play and end-of-song in the same cycle, and suppress song_done in that cycle.
REQ-027 SHALL, when play falls in WAIT_BEATS, ignore beats while paused and resume the count unchanged when play returns.

Reset
REQ-028 SHALL, on reset low, asynchronously force FSM=IDLE, addr=0, song_idx=0, beat counter=0, song_note=12'h000, load_new_note=0 and song_done=0.
REQ-029 SHALL, on a mid-note reset, discard the in-flight note with no strobe; operation after release is identical to power-up.

Configuration
REQ-030 SHALL, with macro SONG_LOOP_EN defined, go DONE->FETCH with addr=0 (song loops, song_done still pulses); without it, go DONE->IDLE and wait for play or next_song.

Structure
REQ-031 SHALL place mode encodings (JAM_SESH, COMPOSER, SONG_PLAYER), note field widths/offsets, END_MARKER and FSM state encodings in the shared package player_piano_pkg.
REQ-032 SHALL use one sub-module, song_rom: synchronous-read ROM addressed {song_idx, addr}, returning a 12-bit word.

Verification
REQ-033 SHALL verify: ROM song 0 = {6'd2,6'd4}, 12'h000; play=1, one beat every 5 cycles -> one strobe with 12'h084, next fetch exactly on the 2nd beat after issue, then song_done pulse.
REQ-034 SHALL verify: chord words {0,4}, {0,6}, {6'd1,6'd8} -> strobes on 3 cycles spaced by 3, song_note 12'h004, 12'h006, 12'h048.
REQ-035 SHALL verify: play dropped for 3 beats inside a 4-beat note -> note lasts 4 counted beats; no strobe while paused.
REQ-036 SHALL verify: next_song asserted in the same cycle as the terminating beat and on song_idx=3 -> song_idx=0, addr=0, no song_done.
REQ-037 SHALL verify: reset asserted mid-WAIT_BEATS -> all outputs 0 immediately without a clock edge; after release the first strobe carries the address-0 word.
REQ-038 SHALL verify: state=2'b00 for 20 cycles -> load_new_note stays 0; with SONG_LOOP_EN defined, the first note re-issues after song_done.
